// File: rtl/pc_gen_unit_if.sv
// Fetch-PC generator bus: EX-stage resolution and trap inputs, fetch PC,
// prediction and performance-counter outputs.
interface pc_gen_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             stall_f;
    logic             ex_valid;
    logic [2:0]       ex_cond;
    logic [2:0]       ex_branch;
    logic             ex_jal;
    logic             ex_jalr;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_imm;
    logic [XLEN-1:0]  ex_rs1;
    logic             ex_pred_taken;
    logic [XLEN-1:0]  ex_pred_tgt;
    logic             trap_valid;
    logic [XLEN-1:0]  trap_vec;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  npc;
    logic             flush;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_tgt;
    logic [CNT_W-1:0] perf_ctl;
    logic [CNT_W-1:0] perf_mispred;

    modport master (
        output stall_f, ex_valid, ex_cond, ex_branch, ex_jal, ex_jalr,
               ex_pc, ex_imm, ex_rs1, ex_pred_taken, ex_pred_tgt,
               trap_valid, trap_vec,
        input  pc, npc, flush, pred_taken, pred_tgt, perf_ctl, perf_mispred
    );

    modport slave (
        input  stall_f, ex_valid, ex_cond, ex_branch, ex_jal, ex_jalr,
               ex_pc, ex_imm, ex_rs1, ex_pred_taken, ex_pred_tgt,
               trap_valid, trap_vec,
        output pc, npc, flush, pred_taken, pred_tgt, perf_ctl, perf_mispred
    );
endinterface

// File: rtl/pc_gen_unit.sv
// IF-stage PC generator: sequential / EX redirect / trap sources, flush and
// control-transfer counters. Define PC_BTB_EN to add a direct-mapped BTB.
module pc_gen_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              INST_BYTES = 4,
    parameter int              CNT_W      = 32,
    parameter int              BTB_IDX_W  = 4
) (
    input  logic           clk,
    input  logic           rstn,
    pc_gen_unit_if.slave   bus
);
    localparam logic [XLEN-1:0] INST_STEP = XLEN'(INST_BYTES);
    localparam logic [XLEN-1:0] LSB_CLR   = ~XLEN'(1);

    logic             ctl;
    logic             taken;
    logic             redirect;
    logic             cnt_en;
    logic [XLEN-1:0]  act_tgt;
    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  npc;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_tgt;
    logic [CNT_W-1:0] perf_ctl_q;
    logic [CNT_W-1:0] perf_mispred_q;

    assign ctl   = bus.ex_valid & (bus.ex_jal | bus.ex_jalr | (|bus.ex_branch));
    assign taken = bus.ex_valid & (bus.ex_jal | bus.ex_jalr | (|(bus.ex_cond & bus.ex_branch)));

    always_comb begin
        if (!taken)
            act_tgt = bus.ex_pc + INST_STEP;
        else if (bus.ex_jalr)
            act_tgt = (bus.ex_rs1 + bus.ex_imm) & LSB_CLR;
        else
            act_tgt = bus.ex_pc + bus.ex_imm;
    end

    // Counters and BTB advance with the pipeline, or when EX forces a redirect.
    assign cnt_en = ~bus.stall_f | redirect;

`ifdef PC_BTB_EN
    localparam int ENTRIES = 1 << BTB_IDX_W;
    localparam int TAG_W   = XLEN - BTB_IDX_W - 2;

    logic             btb_valid [ENTRIES];
    logic [TAG_W-1:0] btb_tag   [ENTRIES];
    logic [XLEN-1:0]  btb_tgt   [ENTRIES];
    logic [1:0]       btb_ctr   [ENTRIES];

    logic [BTB_IDX_W-1:0] f_idx;
    logic [BTB_IDX_W-1:0] u_idx;
    logic [TAG_W-1:0]     f_tag;
    logic [TAG_W-1:0]     u_tag;
    logic                 f_hit;
    logic                 u_hit;
    logic                 btb_upd;

    assign f_idx   = pc_q[BTB_IDX_W+1:2];
    assign f_tag   = pc_q[XLEN-1:BTB_IDX_W+2];
    assign u_idx   = bus.ex_pc[BTB_IDX_W+1:2];
    assign u_tag   = bus.ex_pc[XLEN-1:BTB_IDX_W+2];
    assign f_hit   = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
    assign u_hit   = btb_valid[u_idx] && (btb_tag[u_idx] == u_tag);
    assign btb_upd = ctl & cnt_en;

    assign pred_taken = f_hit & btb_ctr[f_idx][1];
    assign pred_tgt   = f_hit ? btb_tgt[f_idx] : '0;
    assign redirect   = ctl & ((taken != bus.ex_pred_taken) |
                               (taken & (act_tgt != bus.ex_pred_tgt)));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < ENTRIES; i++)
                btb_valid[i] <= 1'b0;
        end else if (btb_upd) begin
            btb_valid[u_idx] <= 1'b1;
        end
    end

    // NOTE: only the valid bits need reset; tag/target/counter contents are
    // never observed while the entry is invalid, so they stay plain RAM.
    always_ff @(posedge clk) begin
        if (btb_upd) begin
            btb_tag[u_idx] <= u_tag;
            btb_tgt[u_idx] <= act_tgt;
            if (!u_hit)
                btb_ctr[u_idx] <= taken ? 2'd2 : 2'd1;
            else if (taken)
                btb_ctr[u_idx] <= (btb_ctr[u_idx] == 2'd3) ? 2'd3 : btb_ctr[u_idx] + 2'd1;
            else
                btb_ctr[u_idx] <= (btb_ctr[u_idx] == 2'd0) ? 2'd0 : btb_ctr[u_idx] - 2'd1;
        end
    end
`else
    logic unused_pred;

    assign pred_taken  = 1'b0;
    assign pred_tgt    = '0;
    assign redirect    = taken;
    assign unused_pred = ^{bus.ex_pred_taken, bus.ex_pred_tgt, (BTB_IDX_W > 0)};
`endif

    // NOTE: every branch of this always_comb assigns npc, so no latch is inferred.
    always_comb begin
        npc = pc_q + INST_STEP;
        if (bus.trap_valid)
            npc = bus.trap_vec;
        else if (redirect)
            npc = act_tgt;
        else if (bus.stall_f)
            npc = pc_q;
        else if (pred_taken)
            npc = pred_tgt;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q           <= RESET_PC;
            perf_ctl_q     <= '0;
            perf_mispred_q <= '0;
        end else begin
            pc_q <= npc;
            if (cnt_en) begin
                perf_ctl_q     <= perf_ctl_q + CNT_W'(ctl);
                perf_mispred_q <= perf_mispred_q + CNT_W'(redirect & ~bus.trap_valid);
            end
        end
    end

    assign bus.pc           = pc_q;
    assign bus.npc          = npc;
    assign bus.flush        = bus.trap_valid | redirect;
    assign bus.pred_taken   = pred_taken;
    assign bus.pred_tgt     = pred_tgt;
    assign bus.perf_ctl     = perf_ctl_q;
    assign bus.perf_mispred = perf_mispred_q;
endmodule
